ram_dp_lanes_clr: RTL and testbench

//   Simple dual-port synchronous RAM: one write port with per-lane write enables, one independent read port.

---
 rtl/ram_dp_lanes_clr_if.sv | 58 +++++
 rtl/ram_dp_lanes_clr.sv | 176 +++++++++++++++++
 tb/tb_ram_dp_lanes_clr.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_lanes_clr_if.sv
// Bus bundle for ram_dp_lanes_clr: write port, read port and clear control.
//   master : driver side (testbench / datapath) -- drives requests, sees status and read data
//   slave  : RAM side -- receives requests, returns busy, wr_drop, rdata, rvalid
//   clr_req  clear sweep request pulse          busy     clear sweep in progress
//   wr_en    write request                      waddr    write address
//   wdata    write data                         wbe      per-lane write enables
//   wr_drop  write discarded while busy         rd_en    read request
//   raddr    read address                       rdata    read data
//   rvalid   rdata carries a completing read
interface ram_dp_lanes_clr_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 4
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  clr_req;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [LANES-1:0]      wbe;
    logic                  wr_drop;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output clr_req,
        output wr_en,
        output waddr,
        output wdata,
        output wbe,
        output rd_en,
        output raddr,
        input  busy,
        input  wr_drop,
        input  rdata,
        input  rvalid
    );

    modport slave (
        input  clr_req,
        input  wr_en,
        input  waddr,
        input  wdata,
        input  wbe,
        input  rd_en,
        input  raddr,
        output busy,
        output wr_drop,
        output rdata,
        output rvalid
    );

endinterface

// File: rtl/ram_dp_lanes_clr.sv
// Simple dual-port synchronous RAM with per-lane write enables, selectable
// read-during-write behaviour, optional output register and a hardware
// clear sweep that runs after every reset and on request.
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    ram_dp_lanes_clr_if.slave (write port, read port, clear control)
// Parameters:
//   ADDR_WIDTH  address bits, DEPTH = 1 << ADDR_WIDTH
//   DATA_WIDTH  word width, a multiple of LANE_WIDTH
//   LANE_WIDTH  bits per write-enable lane
//   RDW_MODE    same-address read+write: 0 = old word, 1 = lane-merged new word
//   OUT_REG     1 adds an output register (read latency 1 + OUT_REG)
//   CLR_VALUE   value written to every word by the clear sweep
module ram_dp_lanes_clr #(
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           LANE_WIDTH = 4,
    parameter bit                    RDW_MODE   = 1'b0,
    parameter bit                    OUT_REG    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_dp_lanes_clr_if.slave bus
);

    localparam int unsigned           DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned           LANES     = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [ADDR_WIDTH-1:0] clr_ptr_next;
    logic                  busy_q;
    logic                  busy_next;
    logic                  drop_q;
    logic                  drop_next;
    logic                  wr_fire;
    logic                  rd_fire;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Next-state, sweep pointer and port gating
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        drop_next    = 1'b0;
        wr_fire      = 1'b0;
        rd_fire      = 1'b0;
        case (state)
            CLEAR: begin
                // Ports are blocked; a masked-off write is not worth reporting.
                clr_ptr_next = clr_ptr + ADDR_WIDTH'(1);
                drop_next    = bus.wr_en && (bus.wbe != '0);
                if (clr_ptr == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Traffic presented alongside clr_req still completes.
                wr_fire = bus.wr_en && (bus.wbe != '0);
                rd_fire = bus.rd_en;
                if (bus.clr_req) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_ptr_next = '0;
            end
        endcase
        busy_next = (state_next == CLEAR);
    end

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy_q  <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
            busy_q  <= busy_next;
            drop_q  <= drop_next;
        end
    end

    // Storage: sweep writes in CLEAR, lane-masked writes in RUN; no reset of contents
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= CLR_VALUE;
            end else if (wr_fire) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    if (bus.wbe[i]) begin
                        mem[bus.waddr][i*LANE_WIDTH +: LANE_WIDTH] <=
                            bus.wdata[i*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // Read word, optionally forwarding the lanes being written this cycle
    always_comb begin
        rd_word = mem[bus.raddr];
        if (RDW_MODE && wr_fire && (bus.waddr == bus.raddr)) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (bus.wbe[i]) begin
                    rd_word[i*LANE_WIDTH +: LANE_WIDTH] = bus.wdata[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Optional first pipeline stage; it keeps draining while the sweep runs
    generate
        if (OUT_REG) begin : g_out_reg
            logic                  p1_valid;
            logic [DATA_WIDTH-1:0] p1_data;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    p1_valid <= 1'b0;
                    p1_data  <= '0;
                end else begin
                    p1_valid <= rd_fire;
                    if (rd_fire) begin
                        p1_data <= rd_word;
                    end
                end
            end

            assign stage_valid = p1_valid;
            assign stage_data  = p1_data;
        end else begin : g_no_out_reg
            assign stage_valid = rd_fire;
            assign stage_data  = rd_word;
        end
    endgenerate

    // Output register: rdata holds its last value between completions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= stage_valid;
            if (stage_valid) begin
                rdata_q <= stage_data;
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.wr_drop = drop_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_ram_dp_lanes_clr.sv
// Directed bench for ram_dp_lanes_clr. Two instances run in lockstep:
// dut0 (RDW_MODE=0, OUT_REG=0) and dut1 (RDW_MODE=1, OUT_REG=1).
// Expected read results are queued when a read is accepted and popped when due.
module tb_ram_dp_lanes_clr;

    typedef struct {
        int         due;
        logic [7:0] data;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_req = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [1:0] wbe = '0;
    logic       rd_en = 1'b0;
    logic [3:0] raddr = '0;
    logic [7:0] rexp0 = '0;
    logic [7:0] rexp1 = '0;

    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   busy_run = 0;
    int   last_run = 0;
    logic m_busy = 1'b1;
    logic m_drop = 1'b0;
    int   m_ptr = 0;
    sb_t  q0[$];
    sb_t  q1[$];

    always #5 clk = ~clk;

    ram_dp_lanes_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4)) bus0 ();
    ram_dp_lanes_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4)) bus1 ();

    assign bus0.clr_req = clr_req;
    assign bus0.wr_en   = wr_en;
    assign bus0.waddr   = waddr;
    assign bus0.wdata   = wdata;
    assign bus0.wbe     = wbe;
    assign bus0.rd_en   = rd_en;
    assign bus0.raddr   = raddr;
    assign bus1.clr_req = clr_req;
    assign bus1.wr_en   = wr_en;
    assign bus1.waddr   = waddr;
    assign bus1.wdata   = wdata;
    assign bus1.wbe     = wbe;
    assign bus1.rd_en   = rd_en;
    assign bus1.raddr   = raddr;

    ram_dp_lanes_clr #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4),
        .RDW_MODE(1'b0), .OUT_REG(1'b0), .CLR_VALUE(8'h00)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    ram_dp_lanes_clr #(
        .ADDR_WIDTH(4), .DATA_WIDTH(8), .LANE_WIDTH(4),
        .RDW_MODE(1'b1), .OUT_REG(1'b1), .CLR_VALUE(8'h00)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        wbe     = 2'b00;
        rd_en   = 1'b0;
    endtask

    // One clock: update the reference at the edge, then check both DUTs 1 ns later.
    task automatic cyc();
        sb_t e;
        @(posedge clk);
        cyc_n++;
        if (!rst_n) begin
            m_busy   = 1'b1;
            m_ptr    = 0;
            m_drop   = 1'b0;
            busy_run = 0;
            q0.delete();
            q1.delete();
        end else if (m_busy) begin
            m_drop = wr_en && (wbe != 2'b00);
            if (m_ptr == 15) m_busy = 1'b0;
            m_ptr++;
        end else begin
            m_drop = 1'b0;
            if (rd_en) begin
                e.due = cyc_n;     e.data = rexp0; q0.push_back(e);
                e.due = cyc_n + 1; e.data = rexp1; q1.push_back(e);
            end
            if (clr_req) begin
                m_busy = 1'b1;
                m_ptr  = 0;
            end
        end
        #1;
        chk("busy0", 32'(bus0.busy), 32'(m_busy));
        chk("busy1", 32'(bus1.busy), 32'(m_busy));
        chk("wr_drop0", 32'(bus0.wr_drop), 32'(m_drop));
        chk("wr_drop1", 32'(bus1.wr_drop), 32'(m_drop));
        if (q0.size() > 0 && q0[0].due == cyc_n) begin
            chk("rvalid0", 32'(bus0.rvalid), 32'd1);
            chk("rdata0", 32'(bus0.rdata), 32'(q0[0].data));
            void'(q0.pop_front());
        end else begin
            chk("rvalid0_idle", 32'(bus0.rvalid), 32'd0);
        end
        if (q1.size() > 0 && q1[0].due == cyc_n) begin
            chk("rvalid1", 32'(bus1.rvalid), 32'd1);
            chk("rdata1", 32'(bus1.rdata), 32'(q1[0].data));
            void'(q1.pop_front());
        end else begin
            chk("rvalid1_idle", 32'(bus1.rvalid), 32'd0);
        end
        if (bus0.busy === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [7:0] d, input logic [1:0] be);
        wr_en = 1'b1; waddr = a; wdata = d; wbe = be;
        cyc();
        idle();
    endtask

    task automatic do_rd(input logic [3:0] a, input logic [7:0] e0, input logic [7:0] e1);
        rd_en = 1'b1; raddr = a; rexp0 = e0; rexp1 = e1;
        cyc();
        idle();
    endtask

    // Wait for the sweep to finish (bounded) and check it lasted 16 cycles.
    task automatic wait_idle();
        int n = 0;
        while (bus0.busy === 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk("sweep_timeout", 32'(bus0.busy), 32'd0);
        chk("sweep_len", 32'(last_run), 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: reset, power-up sweep, memory reads back as clear value
        idle();
        rst_n = 1'b0;
        drain(3);
        chk("rst_rdata0", 32'(bus0.rdata), 32'h0);
        chk("rst_rdata1", 32'(bus1.rdata), 32'h0);
        rst_n = 1'b1;
        wait_idle();
        for (int i = 0; i < 16; i++) do_rd(4'(i), 8'h00, 8'h00);
        drain(3);

        // 2: lane masking, wbe=0 write is a no-op without wr_drop
        do_wr(4'd3, 8'hA5, 2'b11);
        do_wr(4'd3, 8'h3C, 2'b01);
        do_rd(4'd3, 8'hAC, 8'hAC);
        do_wr(4'd3, 8'hFF, 2'b00);
        do_rd(4'd3, 8'hAC, 8'hAC);
        drain(3);
        chk("rdata_hold0", 32'(bus0.rdata), 32'hAC);
        chk("rdata_hold1", 32'(bus1.rdata), 32'hAC);

        // 3: same-address read during write (dut0 old word, dut1 merged word)
        do_wr(4'd5, 8'h11, 2'b11);
        wr_en = 1'b1; waddr = 4'd5; wdata = 8'h77; wbe = 2'b10;
        rd_en = 1'b1; raddr = 4'd5; rexp0 = 8'h11; rexp1 = 8'h71;
        cyc();
        idle();
        drain(2);
        do_rd(4'd5, 8'h71, 8'h71);
        drain(3);

        // 4: back-to-back reads, latency 1 (dut0) and 2 (dut1)
        do_wr(4'd1, 8'h1E, 2'b11);
        do_wr(4'd2, 8'h2D, 2'b11);
        do_wr(4'd3, 8'h3C, 2'b11);
        do_rd(4'd1, 8'h1E, 8'h1E);
        do_rd(4'd2, 8'h2D, 8'h2D);
        do_rd(4'd3, 8'h3C, 8'h3C);
        drain(3);

        // 5: requested clear; read issued with clr_req drains, busy traffic blocked
        do_wr(4'd7, 8'h5A, 2'b11);
        rd_en = 1'b1; raddr = 4'd7; rexp0 = 8'h5A; rexp1 = 8'h5A; clr_req = 1'b1;
        cyc();
        idle();
        do_wr(4'd7, 8'hFF, 2'b11);
        do_wr(4'd7, 8'hFF, 2'b00);
        do_rd(4'd7, 8'hEE, 8'hEE);
        clr_req = 1'b1;
        cyc();
        idle();
        drain(10);
        do_wr(4'd0, 8'hFF, 2'b11);
        wait_idle();
        do_rd(4'd7, 8'h00, 8'h00);
        do_rd(4'd0, 8'h00, 8'h00);
        drain(3);

        // 6: reset in the middle of a sweep restarts it from address 0
        do_wr(4'd9, 8'h99, 2'b11);
        clr_req = 1'b1;
        cyc();
        idle();
        drain(6);
        rst_n = 1'b0;
        drain(2);
        rst_n = 1'b1;
        wait_idle();
        for (int i = 0; i < 16; i++) do_rd(4'(i), 8'h00, 8'h00);
        drain(3);

        // reset with a read in flight flushes the pipeline
        do_wr(4'd4, 8'h44, 2'b11);
        do_rd(4'd4, 8'h44, 8'h44);
        rst_n = 1'b0;
        cyc();
        chk("flush_rdata1", 32'(bus1.rdata), 32'h0);
        rst_n = 1'b1;
        wait_idle();
        do_rd(4'd4, 8'h00, 8'h00);
        drain(3);

        chk("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
